// File: rtl/sram_seq_access_ctrl_if.sv
// -----------------------------------------------------------------------------
// sram_seq_access_ctrl_if
// Bundles every non-clock signal of sram_seq_access_ctrl: burst control,
// write stream (valid/ready), read stream (valid/ready) and the Sram port pair.
//
// Modports:
//   master : the controller side (drives busy/done, stream handshakes, sram_*)
//   slave  : the surrounding system (layer engine + Sram)
//
// Signals:
//   start_wr, start_rd      burst start pulses
//   base_addr, len          burst first address / length in words
//   addr_stride             address step (only with SEQ_CTRL_STRIDE_EN)
//   busy, done              burst status
//   in_valid/in_ready/in_data     write stream
//   out_valid/out_ready/out_data  read stream
//   sram_csen, sram_wr_en, sram_wr_addr, sram_wr_data,
//   sram_rd_en, sram_rd_addr, sram_rd_data   Sram port pair
// -----------------------------------------------------------------------------
interface sram_seq_access_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  start_wr;
    logic                  start_rd;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH:0]   len;
`ifdef SEQ_CTRL_STRIDE_EN
    logic [ADDR_WIDTH-1:0] addr_stride;
`endif
    logic                  busy;
    logic                  done;

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    logic                  sram_csen;
    logic                  sram_wr_en;
    logic [ADDR_WIDTH-1:0] sram_wr_addr;
    logic [DATA_WIDTH-1:0] sram_wr_data;
    logic                  sram_rd_en;
    logic [ADDR_WIDTH-1:0] sram_rd_addr;
    logic [DATA_WIDTH-1:0] sram_rd_data;

    modport master (
`ifdef SEQ_CTRL_STRIDE_EN
        input  addr_stride,
`endif
        input  start_wr, start_rd, base_addr, len,
        output busy, done,
        input  in_valid, in_data,
        output in_ready,
        output out_valid, out_data,
        input  out_ready,
        output sram_csen, sram_wr_en, sram_wr_addr, sram_wr_data,
        output sram_rd_en, sram_rd_addr,
        input  sram_rd_data
    );

    modport slave (
`ifdef SEQ_CTRL_STRIDE_EN
        output addr_stride,
`endif
        output start_wr, start_rd, base_addr, len,
        input  busy, done,
        output in_valid, in_data,
        input  in_ready,
        input  out_valid, out_data,
        output out_ready,
        input  sram_csen, sram_wr_en, sram_wr_addr, sram_wr_data,
        input  sram_rd_en, sram_rd_addr,
        output sram_rd_data
    );
endinterface

// File: rtl/sram_seq_access_ctrl.sv
// -----------------------------------------------------------------------------
// sram_seq_access_ctrl
// Sequential burst initiator for a synchronous Sram port pair. A write burst
// streams words from a valid/ready input into consecutive addresses; a read
// burst streams them back out through a 2-entry skid FIFO that absorbs the
// Sram's 1-cycle read latency and keeps 1 word/cycle under backpressure.
//
// Ports:
//   clk    clock, all logic on posedge
//   rst_n  asynchronous active-low reset
//   bus    sram_seq_access_ctrl_if.master (control, streams, Sram port pair)
//
// Optional feature: define SEQ_CTRL_STRIDE_EN to add bus.addr_stride; the
// address then advances by the stride sampled at start instead of by 1.
// -----------------------------------------------------------------------------
module sram_seq_access_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_DEPTH = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sram_seq_access_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(DATA_DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE   = (ADDR_WIDTH+1)'(1);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH:0]   addr_sum;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   beat_cnt;   // write beats or read pops so far
    logic [ADDR_WIDTH:0]   issue_cnt;  // Sram reads issued so far
    logic                  pend;       // read issued last cycle, data arrives now
    logic                  done_q;

    logic [DATA_WIDTH-1:0] fifo_mem [2];
    logic                  fifo_wr_ptr, fifo_rd_ptr;
    logic [1:0]            fifo_cnt;

    logic                  wr_beat, pop, rd_issue, last_wr, last_pop, start_any;
    logic [2:0]            occ;

`ifdef SEQ_CTRL_STRIDE_EN
    logic [ADDR_WIDTH-1:0] step_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            step_q <= '0;
        else if (state == IDLE && start_any)
            step_q <= bus.addr_stride;
    end

    assign step = step_q;
`else
    assign step = ADDR_WIDTH'(1);
`endif

    // cur_addr and step are both below DEPTH, so one conditional subtract wraps.
    assign addr_sum  = {1'b0, cur_addr} + {1'b0, step};
    assign addr_next = (addr_sum >= DEPTH) ? ADDR_WIDTH'(addr_sum - DEPTH)
                                           : addr_sum[ADDR_WIDTH-1:0];

    assign start_any = bus.start_wr | bus.start_rd;
    assign wr_beat   = (state == WRITE) && bus.in_valid;
    assign pop       = (fifo_cnt != 2'd0) && bus.out_ready;
    assign last_wr   = wr_beat && (beat_cnt == len_q - ONE);
    assign last_pop  = (state == READ) && pop && (beat_cnt == len_q - ONE);

    // Issue only if the FIFO can still take the word after the one in flight.
    always_comb begin
        occ      = {2'b00, pend} + {1'b0, fifo_cnt} - {2'b00, pop};
        rd_issue = (state == READ) && (issue_cnt < len_q) && (occ < 3'd2);
    end

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and a latch cannot be inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start_wr && bus.len != '0)
                    state_nxt = WRITE;
                else if (bus.start_rd && bus.len != '0)
                    state_nxt = READ;
            end
            WRITE:   if (last_wr)  state_nxt = IDLE;
            READ:    if (last_pop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur_addr  <= '0;
            len_q     <= '0;
            beat_cnt  <= '0;
            issue_cnt <= '0;
            pend      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state  <= state_nxt;
            pend   <= rd_issue;
            // A zero-length start completes immediately without touching the Sram.
            done_q <= (state == IDLE && start_any && bus.len == '0) || last_wr || last_pop;
            if (state == IDLE) begin
                if (start_any) begin
                    cur_addr  <= bus.base_addr;
                    len_q     <= bus.len;
                    beat_cnt  <= '0;
                    issue_cnt <= '0;
                end
            end else begin
                if (wr_beat || rd_issue)
                    cur_addr <= addr_next;
                if (wr_beat || pop)
                    beat_cnt <= beat_cnt + ONE;
                if (rd_issue)
                    issue_cnt <= issue_cnt + ONE;
            end
        end
    end

    // NOTE: the skid FIFO storage is reset because its head drives out_data,
    // which must read 0 after reset; larger memories would normally not be.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++)
                fifo_mem[i] <= '0;
            fifo_wr_ptr <= 1'b0;
            fifo_rd_ptr <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else begin
            if (pend) begin
                fifo_mem[fifo_wr_ptr] <= bus.sram_rd_data;
                fifo_wr_ptr           <= ~fifo_wr_ptr;
            end
            if (pop)
                fifo_rd_ptr <= ~fifo_rd_ptr;
            fifo_cnt <= fifo_cnt + {1'b0, pend} - {1'b0, pop};
        end
    end

    assign bus.busy         = (state != IDLE);
    assign bus.done         = done_q;
    assign bus.in_ready     = (state == WRITE);
    assign bus.out_valid    = (fifo_cnt != 2'd0);
    assign bus.out_data     = fifo_mem[fifo_rd_ptr];
    assign bus.sram_wr_en   = wr_beat;
    assign bus.sram_wr_addr = cur_addr;
    assign bus.sram_wr_data = bus.in_data;
    assign bus.sram_rd_en   = rd_issue;
    assign bus.sram_rd_addr = cur_addr;
    assign bus.sram_csen    = wr_beat | rd_issue;
endmodule
